// File: rtl/pwm_dt_pkg.sv
// Shared types and constants for the complementary gate-drive dead-time stage.
//   dt_state_t   : per-channel half-bridge state
//   DT_MIN       : smallest dead time ever applied (a request of 0 maps here)
//   DT_W_DEFAULT : default width of the dead-time counter
package pwm_dt_pkg;

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_DT_HI = 3'd1,
        ST_HI    = 3'd2,
        ST_DT_LO = 3'd3,
        ST_LO    = 3'd4
    } dt_state_t;

    localparam int DT_MIN       = 1;
    localparam int DT_W_DEFAULT = 6;

endpackage

// File: rtl/pwm_deadtime_channel.sv
// One half-bridge: dead-time FSM, down-counter and registered gate outputs.
//   clk, rst : clock, synchronous active-high reset
//   kill     : forces OFF and clears the counter; overrides every transition
//   pwm_q    : registered PWM phase bit for this channel
//   d_eff    : effective dead time (never 0), captured on entry to a DT state
//   hi_out   : high-side gate enable
//   lo_out   : low-side gate enable
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_OFF   | both switches off (reset or kill); leaves via a DT state
//   ST_DT_HI | both off, counting down before turning the high side on
//   ST_HI    | high side on
//   ST_DT_LO | both off, counting down before turning the low side on
//   ST_LO    | low side on
module dt_channel
    import pwm_dt_pkg::*;
#(
    parameter int DT_W = DT_W_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            kill,
    input  logic            pwm_q,
    input  logic [DT_W-1:0] d_eff,
    output logic            hi_out,
    output logic            lo_out
);

    localparam logic [DT_W-1:0] CNT_ONE = DT_W'(DT_MIN);

    dt_state_t       state, state_nxt;
    logic [DT_W-1:0] cnt, cnt_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_OFF;
            cnt    <= '0;
            hi_out <= 1'b0;
            lo_out <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            // Outputs are a registered decode of the next state, so they
            // always match the state register with no extra cycle of delay.
            hi_out <= (state_nxt == ST_HI);
            lo_out <= (state_nxt == ST_LO);
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        if (kill) begin
            state_nxt = ST_OFF;
            cnt_nxt   = '0;
        end else begin
            case (state)
                ST_OFF: begin
                    state_nxt = pwm_q ? ST_DT_HI : ST_DT_LO;
                    cnt_nxt   = d_eff;
                end
                ST_LO: begin
                    if (pwm_q) begin
                        state_nxt = ST_DT_HI;
                        cnt_nxt   = d_eff;
                    end
                end
                ST_HI: begin
                    if (!pwm_q) begin
                        state_nxt = ST_DT_LO;
                        cnt_nxt   = d_eff;
                    end
                end
                ST_DT_HI: begin
                    // Pulse shorter than the dead time: the high side never
                    // turned on, so the low side may return immediately.
                    if (!pwm_q) begin
                        state_nxt = ST_LO;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_ONE) begin
                        state_nxt = ST_HI;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                ST_DT_LO: begin
                    if (pwm_q) begin
                        state_nxt = ST_HI;
                        cnt_nxt   = '0;
                    end else if (cnt == CNT_ONE) begin
                        state_nxt = ST_LO;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt - CNT_ONE;
                    end
                end
                default: begin
                    state_nxt = ST_OFF;
                    cnt_nxt   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pwm_deadtime.sv
// Complementary gate-drive stage with programmable dead time, latched fault
// shutdown and an enable gate.
//   clk, rst     : clock, synchronous active-high reset
//   en           : 1 = drive bridges, 0 = all outputs low (not latched)
//   dead_cycles  : dead time in clk cycles (0 behaves as 1)
//   pwm_in       : PWM phase bits, one per half-bridge
//   fault_in     : external fault, active-high
//   fault_clr    : single-cycle pulse clearing the latched fault
//   hi_out       : high-side gate enables
//   lo_out       : low-side gate enables
//   fault_active : latched fault status
module pwm_deadtime
    import pwm_dt_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DT_W     = DT_W_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [DT_W-1:0]     dead_cycles,
    input  logic [CHANNELS-1:0] pwm_in,
    input  logic                fault_in,
    input  logic                fault_clr,
    output logic [CHANNELS-1:0] hi_out,
    output logic [CHANNELS-1:0] lo_out,
    output logic                fault_active
);

    localparam logic [DT_W-1:0] D_MIN = DT_W'(DT_MIN);

    logic [CHANNELS-1:0] pwm_q;
    logic                fault_q;
    logic                en_q;
    logic                kill;
    logic [DT_W-1:0]     d_eff;

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q   <= '0;
            fault_q <= 1'b0;
            en_q    <= 1'b0;
        end else begin
            pwm_q   <= pwm_in;
            fault_q <= fault_in;
            en_q    <= en;
        end
    end

    // A fault still present at fault_q wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_active <= 1'b0;
        end else if (fault_q) begin
            fault_active <= 1'b1;
        end else if (fault_clr) begin
            fault_active <= 1'b0;
        end
    end

    // fault_q is the latch's set term; including it here lets the bridges
    // shut off on the same edge the latch sets, two edges after fault_in.
    assign kill  = fault_active | fault_q | ~en_q;
    assign d_eff = (dead_cycles == '0) ? D_MIN : dead_cycles;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        dt_channel #(
            .DT_W (DT_W)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .kill   (kill),
            .pwm_q  (pwm_q[i]),
            .d_eff  (d_eff),
            .hi_out (hi_out[i]),
            .lo_out (lo_out[i])
        );
    end

endmodule
